// File: rtl/tx_sched.sv
// tx_sched: pops words from a FWFT FIFO and feeds them byte-wise to a UART TX with start-timeout retry
module tx_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int BUS_WIDTH  = 8,
   parameter int START_TO   = 15
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FIFO_EMPTY,
   input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
   output logic                  FIFO_RD_INC,
   input  logic                  WORD_MODE,
   input  logic                  TX_BUSY,
   output logic [BUS_WIDTH-1:0]  TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  RETRY_ERR,
   output logic [7:0]            BYTE_CNT
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [BUS_WIDTH-1:0]  tx_data_q, tx_data_d;
   logic [3:0]            timer_q, timer_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  hi_pend_q, hi_pend_d;
   logic                  sel_hi_q, sel_hi_d;
   logic                  rd_inc_q, rd_inc_d;
   logic                  vld_q, vld_d;
   logic                  err_q, err_d;
   logic [3:0]            timer_nxt;
   logic [BUS_WIDTH-1:0]  sel_byte;

   assign timer_nxt = timer_q + 4'd1;
   assign sel_byte  = sel_hi_q ? word_q[2*BUS_WIDTH-1:BUS_WIDTH] : word_q[BUS_WIDTH-1:0];

   assign FIFO_RD_INC = rd_inc_q;
   assign TX_P_DATA   = tx_data_q;
   assign TX_D_VLD    = vld_q;
   assign RETRY_ERR   = err_q;
   assign BYTE_CNT    = cnt_q;

   // next-state and output decode; pulses default low so they last one cycle
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      tx_data_d = tx_data_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      hi_pend_d = hi_pend_q;
      sel_hi_d  = sel_hi_q;
      rd_inc_d  = 1'b0;
      vld_d     = 1'b0;
      err_d     = err_q;
      case (state_q)
         IDLE: if (!FIFO_EMPTY) begin
            word_d    = FIFO_RD_DATA;
            hi_pend_d = WORD_MODE;
            sel_hi_d  = 1'b0;
            rd_inc_d  = 1'b1;
            state_d   = SEND;
         end
         SEND: if (!TX_BUSY) begin
            tx_data_d = sel_byte;
            vld_d     = 1'b1;
            timer_d   = 4'd0;
            state_d   = WAIT_START;
         end
         WAIT_START: if (TX_BUSY) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = WAIT_DONE;
         end else begin
            timer_d = timer_nxt;
            if (timer_nxt == 4'(START_TO)) begin
               err_d   = 1'b1;
               state_d = SEND;
            end
         end
         WAIT_DONE: if (!TX_BUSY) begin
            if (!sel_hi_q && hi_pend_q) begin
               sel_hi_d  = 1'b1;
               hi_pend_d = 1'b0;
               state_d   = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers; reset discards any word in flight
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         word_q    <= '0;
         tx_data_q <= '0;
         timer_q   <= '0;
         cnt_q     <= '0;
         hi_pend_q <= 1'b0;
         sel_hi_q  <= 1'b0;
         rd_inc_q  <= 1'b0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         tx_data_q <= tx_data_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         hi_pend_q <= hi_pend_d;
         sel_hi_q  <= sel_hi_d;
         rd_inc_q  <= rd_inc_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: randomized bench with FIFO queue, byte-stream scoreboard and UART busy model
module tb_tx_sched;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        FIFO_EMPTY = 1'b1;
   logic [15:0] FIFO_RD_DATA = '0;
   logic        WORD_MODE = 1'b0;
   logic        TX_BUSY = 1'b0;
   logic        FIFO_RD_INC, TX_D_VLD, RETRY_ERR;
   logic [7:0]  TX_P_DATA, BYTE_CNT;

   int total = 0;
   int bad = 0;
   logic [16:0] fifo_q[$];
   logic [7:0]  exp_q[$];
   int acc_cnt = 0, vld_cnt = 0, pop_cnt = 0, step_no = 0, last_vld_step = 0;
   int busy_left = 0, pend = 0, blen_min = 2, blen_max = 6;
   bit tx_en = 1'b1, rd_prev = 1'b0, in_flight = 1'b0;

   always #5 CLK = ~CLK;

   tx_sched dut (
      .CLK(CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_DATA(FIFO_RD_DATA),
      .FIFO_RD_INC(FIFO_RD_INC), .WORD_MODE(WORD_MODE), .TX_BUSY(TX_BUSY),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .RETRY_ERR(RETRY_ERR), .BYTE_CNT(BYTE_CNT)
   );

   // head word presented fall-through; mode is scrambled while a word is in flight
   task automatic drive_fifo();
      FIFO_EMPTY   = (fifo_q.size() == 0);
      FIFO_RD_DATA = FIFO_EMPTY ? 16'($urandom) : fifo_q[0][15:0];
      WORD_MODE    = (!FIFO_EMPTY && !in_flight) ? fifo_q[0][16] : 1'($urandom);
   endtask

   task automatic push(input logic m, input logic [15:0] w);
      fifo_q.push_back({m, w});
      drive_fifo();
   endtask

   // one clock: protocol monitors, scoreboard, FIFO and UART models
   task automatic step();
      logic [16:0] head;
      logic [7:0]  e;
      @(posedge CLK); #1;
      step_no++;
      if (rd_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (FIFO_RD_INC || TX_D_VLD) begin
         total++;
         if (FIFO_RD_INC && TX_D_VLD) begin
            bad++; $display("FAIL overlap: rd_inc=%b vld=%b, must not both be 1", FIFO_RD_INC, TX_D_VLD);
         end
      end
      if (TX_D_VLD) begin
         vld_cnt++;
         last_vld_step = step_no;
         total++;
         if (TX_BUSY) begin
            bad++; $display("FAIL vld_while_busy: busy=%b want 0", TX_BUSY);
         end
         if (tx_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL unexpected_byte: got %h want none", TX_P_DATA);
            end else begin
               e = exp_q.pop_front();
               if (TX_P_DATA !== e) begin
                  bad++; $display("FAIL byte: got %h want %h", TX_P_DATA, e);
               end
            end
            pend = $urandom_range(2, 4);
         end
      end
      if (FIFO_RD_INC) begin
         pop_cnt++;
         total++;
         if (fifo_q.size() == 0 || exp_q.size() != 0 || TX_BUSY || pend != 0 || busy_left != 0) begin
            bad++; $display("FAIL pop_order: fifo=%0d pending_bytes=%0d busy=%b, want word done", fifo_q.size(), exp_q.size(), TX_BUSY);
         end
         if (fifo_q.size() > 0) begin
            head = fifo_q[0];
            exp_q.push_back(head[7:0]);
            if (head[16]) exp_q.push_back(head[15:8]);
         end
         in_flight = 1'b1;
      end
      rd_prev = FIFO_RD_INC;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) TX_BUSY = 1'b0;
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            TX_BUSY = 1'b1;
            busy_left = $urandom_range(blen_min, blen_max);
            acc_cnt++;
         end
      end
      if (in_flight && exp_q.size() == 0 && pend == 0 && busy_left == 0 && !TX_BUSY) in_flight = 1'b0;
      drive_fifo();
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((fifo_q.size() != 0 || in_flight) && n < limit) begin
         step();
         n++;
      end
      total++;
      if (n >= limit) begin
         bad++; $display("FAIL drain_timeout: cycles=%0d limit=%0d", n, limit);
      end
      repeat (3) step();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge CLK);
      #1;
      total += 5;
      if (FIFO_RD_INC !== 1'b0) begin bad++; $display("FAIL rst_rd_inc: got %b want 0", FIFO_RD_INC); end
      if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", TX_D_VLD); end
      if (TX_P_DATA !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", TX_P_DATA); end
      if (RETRY_ERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", RETRY_ERR); end
      if (BYTE_CNT !== 8'h00) begin bad++; $display("FAIL rst_cnt: got %h want 00", BYTE_CNT); end
      RST = 1'b1;
      repeat (5) step();
      total++;
      if (pop_cnt !== 0) begin bad++; $display("FAIL rst_no_pop: pops=%0d want 0", pop_cnt); end
   endtask

   task automatic test_low_byte();
      int p0 = pop_cnt, v0 = vld_cnt, s;
      blen_min = 10; blen_max = 10;
      push(1'b0, 16'h12A5);
      s = step_no;
      wait_idle(200);
      total += 5;
      if (last_vld_step - s !== 2) begin bad++; $display("FAIL latency: got %0d want 2", last_vld_step - s); end
      if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL low_pops: got %0d want 1", pop_cnt - p0); end
      if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL low_vlds: got %0d want 1", vld_cnt - v0); end
      if (BYTE_CNT !== 8'd1) begin bad++; $display("FAIL low_cnt: got %0d want 1", BYTE_CNT); end
      if (TX_P_DATA !== 8'hA5) begin bad++; $display("FAIL low_hold: got %h want a5", TX_P_DATA); end
   endtask

   task automatic test_word_mode();
      int a0 = acc_cnt, v0 = vld_cnt;
      blen_min = 3; blen_max = 8;
      push(1'b1, 16'hBEEF);
      wait_idle(300);
      total += 3;
      if (vld_cnt - v0 !== 2) begin bad++; $display("FAIL word_vlds: got %0d want 2", vld_cnt - v0); end
      if (BYTE_CNT !== 8'(a0 + 2)) begin bad++; $display("FAIL word_cnt: got %0d want %0d", BYTE_CNT, 8'(a0 + 2)); end
      if (TX_P_DATA !== 8'hBE) begin bad++; $display("FAIL word_last: got %h want be", TX_P_DATA); end
   endtask

   task automatic test_back_to_back();
      int a0 = acc_cnt, p0 = pop_cnt, v0 = vld_cnt, nb = 0;
      logic m;
      blen_min = 3; blen_max = 12;
      for (int i = 0; i < 23; i++) begin
         m = 1'($urandom);
         nb += m ? 2 : 1;
         push(m, 16'($urandom));
      end
      wait_idle(3000);
      total += 4;
      if (pop_cnt - p0 !== 23) begin bad++; $display("FAIL b2b_pops: got %0d want 23", pop_cnt - p0); end
      if (vld_cnt - v0 !== nb) begin bad++; $display("FAIL b2b_vlds: got %0d want %0d", vld_cnt - v0, nb); end
      if (BYTE_CNT !== 8'(a0 + nb)) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", BYTE_CNT, 8'(a0 + nb)); end
      if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      int a0 = acc_cnt, v0 = vld_cnt;
      blen_min = 1; blen_max = 3;
      for (int i = 0; i < 256; i++) push(1'b0, 16'($urandom));
      wait_idle(20000);
      total += 2;
      if (BYTE_CNT !== 8'(a0)) begin bad++; $display("FAIL wrap_cnt: got %0d want %0d", BYTE_CNT, 8'(a0)); end
      if (vld_cnt - v0 !== 256) begin bad++; $display("FAIL wrap_vlds: got %0d want 256", vld_cnt - v0); end
   endtask

   task automatic test_timeout();
      int a0 = acc_cnt, v0, n = 0;
      blen_min = 2; blen_max = 6;
      tx_en = 1'b0;
      v0 = vld_cnt;
      push(1'b0, 16'h34C3);
      while (vld_cnt == v0 && n < 10) begin step(); n++; end
      total++;
      if (vld_cnt == v0) begin bad++; $display("FAIL to_first_vld: vlds=%0d want 1", vld_cnt - v0); end
      v0 = vld_cnt;
      repeat (14) step();
      total += 2;
      if (RETRY_ERR !== 1'b0) begin bad++; $display("FAIL to_early: err=%b want 0", RETRY_ERR); end
      if (vld_cnt !== v0) begin bad++; $display("FAIL to_extra_vld: got %0d want 0", vld_cnt - v0); end
      step();
      total += 2;
      if (RETRY_ERR !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", RETRY_ERR); end
      if (BYTE_CNT !== 8'(a0)) begin bad++; $display("FAIL to_cnt_hold: got %0d want %0d", BYTE_CNT, 8'(a0)); end
      tx_en = 1'b1;
      step();
      total++;
      if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hC3) begin
         bad++; $display("FAIL to_repulse: vld=%b data=%h want 1 c3", TX_D_VLD, TX_P_DATA);
      end
      wait_idle(200);
      total += 2;
      if (BYTE_CNT !== 8'(a0 + 1)) begin bad++; $display("FAIL to_cnt: got %0d want %0d", BYTE_CNT, 8'(a0 + 1)); end
      if (RETRY_ERR !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", RETRY_ERR); end
   endtask

   task automatic test_reset_mid();
      int v0 = vld_cnt, n = 0, p0;
      blen_min = 20; blen_max = 20;
      push(1'b1, 16'h5A3C);
      while (vld_cnt < v0 + 2 && n < 80) begin step(); n++; end
      total++;
      if (vld_cnt < v0 + 2) begin bad++; $display("FAIL mid_hi_vld: vlds=%0d want 2", vld_cnt - v0); end
      repeat (5) step();
      #2 RST = 1'b0;
      #1;
      total += 5;
      if (FIFO_RD_INC !== 1'b0) begin bad++; $display("FAIL mid_rd_inc: got %b want 0", FIFO_RD_INC); end
      if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL mid_vld: got %b want 0", TX_D_VLD); end
      if (TX_P_DATA !== 8'h00) begin bad++; $display("FAIL mid_data: got %h want 00", TX_P_DATA); end
      if (RETRY_ERR !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", RETRY_ERR); end
      if (BYTE_CNT !== 8'h00) begin bad++; $display("FAIL mid_cnt: got %h want 00", BYTE_CNT); end
      TX_BUSY = 1'b0; busy_left = 0; pend = 0; acc_cnt = 0;
      exp_q.delete(); in_flight = 1'b0; rd_prev = 1'b0;
      drive_fifo();
      @(posedge CLK); #1;
      RST = 1'b1;
      p0 = pop_cnt;
      repeat (4) step();
      total++;
      if (pop_cnt !== p0) begin bad++; $display("FAIL mid_no_pop: got %0d want 0", pop_cnt - p0); end
      blen_min = 2; blen_max = 6;
      v0 = vld_cnt;
      push(1'b0, 16'h0077);
      wait_idle(200);
      total += 4;
      if (vld_cnt - v0 !== 1) begin bad++; $display("FAIL mid_fresh_vlds: got %0d want 1", vld_cnt - v0); end
      if (TX_P_DATA !== 8'h77) begin bad++; $display("FAIL mid_fresh_data: got %h want 77", TX_P_DATA); end
      if (BYTE_CNT !== 8'd1) begin bad++; $display("FAIL mid_fresh_cnt: got %0d want 1", BYTE_CNT); end
      if (RETRY_ERR !== 1'b0) begin bad++; $display("FAIL mid_fresh_err: got %b want 0", RETRY_ERR); end
   endtask

   initial begin
      test_reset();
      test_low_byte();
      test_word_mode();
      test_back_to_back();
      test_wrap();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
